// File: rtl/mp_register_file.sv
// Multi-ported register file with two write ports, two read ports
// and a per-register busy scoreboard for in-flight producers.
module mp_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en_0,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(ZERO_REG != 0 && i == 0)) begin
          if (wr_en_1 && wr_addr_1 == ADDR_W'(i)) begin
            regs_q[i] <= wr_data_1;
          end else if (wr_en_0 && wr_addr_0 == ADDR_W'(i)) begin
            regs_q[i] <= wr_data_0;
          end
        end
      end
    end
  end

  // Forwarding is gated by rst_n so reset zeroes read data at once.
  function automatic logic [DATA_W-1:0] rd_word(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] d;
    d = regs_q[a];
    if (BYPASS != 0 && rst_n) begin
      if (wr_en_1 && wr_addr_1 == a) begin
        d = wr_data_1;
      end else if (wr_en_0 && wr_addr_0 == a) begin
        d = wr_data_0;
      end
    end
    if (ZERO_REG != 0 && a == '0) begin
      d = '0;
    end
    return d;
  endfunction

  always_comb begin
    rd_data_a = rd_word(rd_addr_a);
    rd_data_b = rd_word(rd_addr_b);
  end

  assign rd_busy_a = busy_q[rd_addr_a];
  assign rd_busy_b = busy_q[rd_addr_b];

  // Issue is applied after write clears so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en_0 && wr_addr_0 == ADDR_W'(i)) begin
        busy_d[i] = 1'b0;
      end
      if (wr_en_1 && wr_addr_1 == ADDR_W'(i)) begin
        busy_d[i] = 1'b0;
      end
      if (iss_en && iss_addr == ADDR_W'(i)) begin
        busy_d[i] = 1'b1;
      end
    end
    if (flush) begin
      busy_d = '0;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_mp_register_file.sv
// Directed bench for mp_register_file, checking a bypassing
// instance and a non-bypassing instance side by side.
module tb_mp_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        wr_en_0, wr_en_1;
  logic [4:0]  wr_addr_0, wr_addr_1;
  logic [31:0] wr_data_0, wr_data_1;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;

  logic [31:0] rda, rdb, nrda, nrdb;
  logic        bsa, bsb, nbsa, nbsb;
  logic [5:0]  cnt, ncnt;

  int checks = 0;
  int errors = 0;

  mp_register_file dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rda), .rd_data_b(rdb),
    .rd_busy_a(bsa), .rd_busy_b(bsb),
    .wr_en_0(wr_en_0), .wr_en_1(wr_en_1),
    .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1),
    .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .busy_cnt(cnt)
  );

  mp_register_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(nrda), .rd_data_b(nrdb),
    .rd_busy_a(nbsa), .rd_busy_b(nbsb),
    .wr_en_0(wr_en_0), .wr_en_1(wr_en_1),
    .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1),
    .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .busy_cnt(ncnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en_0 = 0; wr_en_1 = 0; iss_en = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    rd_addr_a = 0; rd_addr_b = 0;
    wr_addr_0 = 0; wr_addr_1 = 0;
    wr_data_0 = 0; wr_data_1 = 0;
    iss_addr = 0;
    idle();
    tick();
    tick();
    drv();
    rst_n = 1;

    // Reset state on every address
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      chk("rst_rda", rda | rdb | nrda | nrdb, 32'h0);
      chk("rst_busy", {28'h0, bsa, bsb, nbsa, nbsb}, 32'h0);
    end
    chk("rst_cnt", {26'h0, cnt}, 32'h0);

    // Same-cycle bypass vs not
    drv();
    wr_en_0 = 1; wr_addr_0 = 5; wr_data_0 = 32'h1234_5678;
    rd_addr_a = 5;
    #1;
    chk("byp_on", rda, 32'h1234_5678);
    chk("byp_off", nrda, 32'h0);
    tick();
    chk("byp_off_next", nrda, 32'h1234_5678);
    drv();
    idle();

    // Double write, port 1 priority
    wr_en_0 = 1; wr_addr_0 = 9; wr_data_0 = 32'hAAAA_AAAA;
    wr_en_1 = 1; wr_addr_1 = 9; wr_data_1 = 32'h5555_5555;
    rd_addr_b = 9;
    #1;
    chk("dbl_byp", rdb, 32'h5555_5555);
    chk("dbl_nobyp", nrdb, 32'h0);
    tick();
    drv();
    idle();
    #1;
    chk("dbl_store", rdb, 32'h5555_5555);
    chk("dbl_store_nb", nrdb, 32'h5555_5555);

    // Independent writes to different addresses
    wr_en_0 = 1; wr_addr_0 = 20; wr_data_0 = 32'h0000_0A20;
    wr_en_1 = 1; wr_addr_1 = 21; wr_data_1 = 32'h0000_0B21;
    tick();
    drv();
    idle();
    rd_addr_a = 20; rd_addr_b = 21;
    #1;
    chk("ind_a", rda, 32'h0000_0A20);
    chk("ind_b", rdb, 32'h0000_0B21);

    // Register zero
    wr_en_0 = 1; wr_addr_0 = 0; wr_data_0 = 32'hFFFF_FFFF;
    wr_en_1 = 1; wr_addr_1 = 0; wr_data_1 = 32'hFFFF_FFFF;
    iss_en = 1; iss_addr = 0;
    rd_addr_a = 0;
    #1;
    chk("z_byp", rda, 32'h0);
    tick();
    drv();
    idle();
    #1;
    chk("z_data", rda | nrda, 32'h0);
    chk("z_busy", {31'h0, bsa}, 32'h0);
    chk("z_cnt", {26'h0, cnt}, 32'h0);

    // Scoreboard
    rd_addr_a = 3; rd_addr_b = 7;
    iss_en = 1; iss_addr = 3;
    #1;
    chk("sb_nobyp", {31'h0, bsa}, 32'h0);
    tick();
    chk("sb_cnt1", {26'h0, cnt}, 32'd1);
    chk("sb_b3", {31'h0, bsa}, 32'h1);
    drv();
    iss_addr = 7;
    tick();
    chk("sb_cnt2", {26'h0, cnt}, 32'd2);
    chk("sb_b7", {31'h0, bsb}, 32'h1);
    drv();
    iss_addr = 3;
    wr_en_1 = 1; wr_addr_1 = 3; wr_data_1 = 32'hCAFE_0003;
    tick();
    chk("sb_newprod", {31'h0, bsa}, 32'h1);
    chk("sb_cnt2b", {26'h0, cnt}, 32'd2);
    drv();
    idle();
    wr_en_0 = 1; wr_addr_0 = 7; wr_data_0 = 32'h0000_0077;
    tick();
    chk("sb_clr7", {31'h0, bsb}, 32'h0);
    chk("sb_cnt1b", {26'h0, cnt}, 32'd1);
    drv();
    idle();
    iss_en = 1; iss_addr = 10;
    flush = 1;
    tick();
    drv();
    idle();
    #1;
    chk("fl_cnt", {26'h0, cnt}, 32'd0);
    chk("fl_b3", {31'h0, bsa}, 32'h0);
    chk("fl_d3", rda, 32'hCAFE_0003);
    chk("fl_d7", rdb, 32'h0000_0077);
    rd_addr_a = 5;
    #1;
    chk("fl_d5", rda, 32'h1234_5678);

    // Mid-operation async reset
    iss_en = 1; iss_addr = 12;
    tick();
    drv();
    idle();
    rd_addr_b = 12;
    #1;
    chk("pre_rst_cnt", {26'h0, cnt}, 32'd1);
    wr_en_0 = 1; wr_addr_0 = 5; wr_data_0 = 32'hDEAD_BEEF;
    rst_n = 0;
    #1;
    chk("ar_rda", rda, 32'h0);
    chk("ar_nrda", nrda, 32'h0);
    chk("ar_busy", {31'h0, bsb}, 32'h0);
    chk("ar_cnt", {26'h0, cnt}, 32'h0);
    tick();
    drv();
    idle();
    rst_n = 1;
    #1;
    chk("ar_lost", rda, 32'h0);
    wr_en_0 = 1; wr_addr_0 = 5; wr_data_0 = 32'h0000_BEEF;
    tick();
    drv();
    idle();
    #1;
    chk("post_rst", nrda, 32'h0000_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
